// File: rtl/dma_io_peripheral.sv
// dma_io_peripheral: requester side of a DMA DREQ/DACK/IOR_N/IOW_N handshake.
// A TX FIFO is filled locally and drained by controller reads. An RX FIFO is
// filled by controller writes and drained locally.
// Optional feature macro: DMA_IO_PERIPHERAL_EOP_EN (EOP_N sets a sticky DONE
// flag that masks further requests until DONE_CLR).
module dma_io_peripheral #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int DEMAND = 0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              DIR,
  output logic              DREQ,
  input  logic              DACK,
  input  logic              IOR_N,
  input  logic              IOW_N,
  input  logic              EOP_N,
  input  logic [DATA_W-1:0] DB_IN,
  output logic [DATA_W-1:0] DB_OUT,
  output logic              DB_OE,
  input  logic              TX_VALID,
  input  logic [DATA_W-1:0] TX_DATA,
  output logic              TX_READY,
  output logic              RX_VALID,
  output logic [DATA_W-1:0] RX_DATA,
  input  logic              RX_READY,
  output logic              DONE,
  input  logic              DONE_CLR
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, REQ, ACK, STRB, REL} state_e;

  state_e            state_q, state_d;
  logic              dreq_q, dreq_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] tx_mem_q [DEPTH];
  logic [DATA_W-1:0] rx_mem_q [DEPTH];
  logic [AW:0]       tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic              tx_empty, tx_full, rx_empty, rx_full;
  logic              tx_push, tx_pop, rx_push, rx_pop;
  logic              bus_push, bus_pop;
  logic              strb_low, eop_hit, svc;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);

  assign tx_push = TX_VALID & ~tx_full;
  assign tx_pop  = bus_pop;
  assign rx_push = bus_push;
  assign rx_pop  = RX_READY & ~rx_empty;

  assign TX_READY = ~tx_full;
  assign RX_VALID = ~rx_empty;
  // Heads read as zero when empty so the buses are clean out of reset.
  assign RX_DATA  = rx_empty ? '0 : rx_mem_q[rx_rd_q[AW-1:0]];
  assign DB_OUT   = tx_empty ? '0 : tx_mem_q[tx_rd_q[AW-1:0]];
  assign DB_OE    = DACK & ~IOR_N & ~DIR & ((state_q == ACK) || (state_q == STRB));
  assign DREQ     = dreq_q;
  assign DONE     = done_q;

  // Only the strobe matching the configured direction advances a transfer.
  assign strb_low = DIR ? ~IOW_N : ~IOR_N;

`ifdef DMA_IO_PERIPHERAL_EOP_EN
  assign eop_hit = ~EOP_N & DACK & ((state_q == STRB) || (state_q == REL));
  assign done_d  = (done_q & ~DONE_CLR) | eop_hit;
`else
  logic unused_eop;
  assign unused_eop = &{1'b0, EOP_N, DONE_CLR};
  assign eop_hit    = 1'b0;
  assign done_d     = 1'b0;
`endif

  // eop_hit also masks svc so a REL that sees EOP does not re-request.
  assign svc = (DIR ? ~rx_full : ~tx_empty) & ~done_q & ~eop_hit;

  // Handshake sequencing; bus FIFO moves happen exactly once per transfer.
  always_comb begin
    state_d  = state_q;
    dreq_d   = dreq_q;
    bus_push = 1'b0;
    bus_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        dreq_d = 1'b0;
        if (svc) state_d = REQ;
      end
      REQ: begin
        dreq_d = 1'b1;
        if (DACK) state_d = ACK;
      end
      ACK: begin
        dreq_d = 1'b1;
        if (!DACK) begin
          state_d = REQ;
        end else if (strb_low) begin
          state_d  = STRB;
          bus_push = DIR;
        end
      end
      STRB: begin
        dreq_d = 1'b1;
        if (!strb_low) begin
          state_d = REL;
          bus_pop = ~DIR;
          dreq_d  = (DEMAND != 0);
        end
      end
      REL: begin
        if ((DEMAND != 0) && svc) begin
          state_d = REQ;
          dreq_d  = 1'b1;
        end else begin
          state_d = IDLE;
          dreq_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        dreq_d  = 1'b0;
      end
    endcase
  end

  // Control state, request flag, DONE and FIFO pointers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      dreq_q  <= 1'b0;
      done_q  <= 1'b0;
      tx_wr_q <= '0;
      tx_rd_q <= '0;
      rx_wr_q <= '0;
      rx_rd_q <= '0;
    end else begin
      state_q <= state_d;
      dreq_q  <= dreq_d;
      done_q  <= done_d;
      if (tx_push) tx_wr_q <= tx_wr_q + (AW+1)'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + (AW+1)'(1);
      if (rx_push) rx_wr_q <= rx_wr_q + (AW+1)'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + (AW+1)'(1);
    end
  end

  // FIFO storage; contents are don't-care until the write pointer covers them.
  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem_q[tx_wr_q[AW-1:0]] <= TX_DATA;
    if (rx_push) rx_mem_q[rx_wr_q[AW-1:0]] <= DB_IN;
  end
endmodule

// File: doc/dma_io_peripheral.md
Name: dma_io_peripheral

Overview:
- Single-channel I/O device model/bridge: the requester end of the DMA controller's DREQ/DACK/IOR_N/IOW_N handshake.
- Buffers local-side data in two FIFOs and raises DREQ when it can service a transfer.
- On DACK it drives or captures the data bus under IOR_N/IOW_N strobes.
- One instance per DMA channel; its DREQ feeds one bit of the controller's DREQ[3:0], and it takes the matching DACK bit.

Parameters:
- DATA_W, 8, data bus and FIFO word width.
- DEPTH, 8, entries per FIFO; power of two, minimum 2.
- DEMAND, 0: 0 = single mode (DREQ released after each transfer); 1 = demand mode (DREQ held while a service condition persists).

Ports:
- CLK  in  1  bus clock.
- RESET_N  in  1  asynchronous active-low reset.
- DIR  in  1  0 = device-to-memory (controller asserts IOR_N); 1 = memory-to-device (controller asserts IOW_N); must be quasi-static.
- DREQ  out  1  DMA request, active high.
- DACK  in  1  DMA acknowledge, active high.
- IOR_N  in  1  I/O read strobe, active low.
- IOW_N  in  1  I/O write strobe, active low.
- EOP_N  in  1  terminal count / end-of-process from controller, active low.
- DB_IN  in  DATA_W  data bus sampled on write.
- DB_OUT  out  DATA_W  data bus driven on read.
- DB_OE  out  1  DB_OUT enable.
- TX_VALID / TX_DATA / TX_READY  in / in DATA_W / out  local push into the TX FIFO (device-to-memory).
- RX_VALID / RX_DATA / RX_READY  out / out DATA_W / in  local pop from the RX FIFO (memory-to-device).
- DONE  out  1  sticky end-of-block flag.
- DONE_CLR  in  1  clears DONE.

Behaviour:
- Reset values: DREQ=0, DB_OE=0, DB_OUT=0, RX_VALID=0, TX_READY=1, DONE=0; FIFOs empty; state IDLE. Reset asserted mid-transfer aborts the transfer with no push or pop.
- Service condition `svc`: (DIR=0 and TX count ≥1) or (DIR=1 and RX count ≤ DEPTH-1), and DONE=0.
- FSM states: IDLE, REQ, ACK, STRB, REL.
  - IDLE -> REQ when `svc`. DREQ is registered and goes high the cycle after entry to REQ.
  - REQ -> ACK on DACK=1. DREQ stays high until DACK is seen; it is never withdrawn before DACK.
  - ACK -> STRB on the first cycle where the strobe matching DIR is low (IOR_N when DIR=0, IOW_N when DIR=1) with DACK=1.
  - STRB -> REL when that strobe returns high.
  - REL -> REQ in demand mode if `svc` still holds; otherwise REL -> IDLE. In single mode DREQ drops on entry to REL, giving at least one cycle low between requests.
- Read path (DIR=0):
  - DB_OUT = TX FIFO head; DB_OE = DACK & ~IOR_N in ACK/STRB (combinational).
  - TX pop occurs exactly once, on the IOR_N rising edge (STRB->REL).
- Write path (DIR=1): DB_IN is captured and pushed to RX exactly once, on the ACK->STRB cycle.
- Error handling: the wrong-direction strobe and strobes without DACK are ignored.
- FIFOs:
  - Pointers are DEPTH-wrap with an extra bit for full/empty.
  - TX_READY = ~full; RX_VALID = ~empty.
  - A simultaneous local push/pop and bus pop/push on the same cycle are both honoured; count is unchanged.
  - The bus never pushes to a full FIFO or pops an empty one, because `svc` gates REQ.
- DACK dropping in ACK before the strobe: return to REQ with DREQ kept high and no data movement.

Optional Feature:
- Macro: DMA_IO_PERIPHERAL_EOP_EN.
- Defined:
  - EOP_N low with DACK=1 in STRB or REL sets DONE the next cycle.
  - The current transfer still completes.
  - The FSM then goes to IDLE and `svc` is masked until DONE_CLR.
- Undefined:
  - EOP_N is ignored and DONE is tied 0.
  - DONE_CLR has no effect.

Test Plan:
- Reset: RESET_N low mid-STRB with DIR=0 and TX holding 3 words -> all outputs at reset values, TX empty, DREQ=0.
- DIR=0, single mode, push 0xA5 then 0x3C -> DREQ high until DACK; DB_OUT=0xA5 with DB_OE=1 during IOR_N low; pop on IOR_N rise; DREQ low ≥1 cycle, then second request returns 0x3C.
- DIR=1, DEMAND=1, empty RX, controller writes 0x11..0x18 -> DREQ held continuously; after 8 writes RX is full and DREQ falls; RX pops yield 0x11..0x18 in order.
- DIR=1 with RX holding 7 words; one local pop on the same cycle as a bus push -> count stays 7 and DREQ remains asserted.
- Protocol errors: DACK=1 with IOW_N low while DIR=0, then IOR_N low with DACK=0 -> no FIFO change, DB_OE=0 throughout.
- EOP_EN defined, DIR=0, TX holding 4 words, EOP_N low on the 2nd transfer -> 2 words popped, DONE=1, DREQ stays 0 until DONE_CLR pulse, then requests resume.
